// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXEC/MEM/WB control FSM for the RV32I
// multi-cycle core. It drives every datapath enable and select from the current
// state and the latched opcode. It also enforces a memory-wait timeout and
// halts in TRAP on an illegal opcode or a bus timeout.
//
// Handshake: mem_req is held high while the FSM waits in FETCH or MEM. A request
// completes on the first rising edge at which mem_ready is high. mem_ready is
// ignored in all other states.
//
// Optional build macro PERF_CNT_EN adds the cycle_cnt and instret_cnt outputs.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       branch_taken,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic       alu_src_a,
  output logic       alu_src_b,
  output logic [1:0] alu_op,
  output logic [2:0] state,
  output logic       retire,
  output logic       trap,
  output logic [1:0] trap_cause
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic             run_q;       // low during reset and for the first edge after it
  logic [CNT_W-1:0] wait_cnt;
  logic [1:0]       cause_d;
  logic             timeout_hit;

  // funct3 is decoded by the datapath ALU control, not by this FSM.
  logic unused_funct3;
  assign unused_funct3 = ^funct3;

  assign state       = state_q;
  assign trap        = (state_q == TRAP);
  assign timeout_hit = (wait_cnt == TIMEOUT_VAL);

  // State register, start-up flag, wait counter and trap cause capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      run_q   <= 1'b1;
      state_q <= state_d;
      if (state_d != state_q || mem_ready)
        wait_cnt <= '0;
      else if (run_q && (state_q == FETCH || state_q == MEM))
        wait_cnt <= wait_cnt + CNT_W'(1);
      if (state_d == TRAP && state_q != TRAP)
        trap_cause <= cause_d;
    end
  end

  // Next-state and strobe decode from current state and opcode
  always_comb begin
    state_d    = state_q;
    cause_d    = 2'b00;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    alu_op     = 2'b00;
    retire     = 1'b0;
    if (run_q) begin
      case (state_q)
        FETCH: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = DECODE;
          end else if (timeout_hit) begin
            state_d = TRAP;
            cause_d = 2'b10;
          end
        end
        DECODE: begin
          case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: state_d = EXEC;
            default: begin
              state_d = TRAP;
              cause_d = 2'b01;
            end
          endcase
        end
        EXEC: begin
          case (opcode)
            OP_R: begin
              alu_op  = 2'b10;
              state_d = WB;
            end
            OP_I: begin
              alu_op    = 2'b10;
              alu_src_b = 1'b1;
              state_d   = WB;
            end
            OP_LOAD, OP_STORE: begin
              alu_src_b = 1'b1;
              state_d   = MEM;
            end
            OP_BRANCH: begin
              alu_op   = 2'b01;
              pc_write = branch_taken;
              pc_src   = 1'b1;
              retire   = 1'b1;
              state_d  = FETCH;
            end
            OP_JAL: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              pc_write  = 1'b1;
              pc_src    = 1'b1;
              state_d   = WB;
            end
            OP_JALR: begin
              alu_src_b = 1'b1;
              pc_write  = 1'b1;
              pc_src    = 1'b1;
              state_d   = WB;
            end
            OP_AUIPC: begin
              alu_src_a = 1'b1;
              alu_src_b = 1'b1;
              state_d   = WB;
            end
            OP_LUI: state_d = WB;
            default: begin
              state_d = TRAP;
              cause_d = 2'b01;
            end
          endcase
        end
        MEM: begin
          mem_req = 1'b1;
          mem_we  = (opcode == OP_STORE);
          if (mem_ready) begin
            if (opcode == OP_STORE) begin
              retire  = 1'b1;
              state_d = FETCH;
            end else begin
              state_d = WB;
            end
          end else if (timeout_hit) begin
            state_d = TRAP;
            cause_d = 2'b10;
          end
        end
        WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = FETCH;
          case (opcode)
            OP_LOAD:         result_src = 2'b01;
            OP_JAL, OP_JALR: result_src = 2'b10;
            OP_LUI:          result_src = 2'b11;
            default:         result_src = 2'b00;
          endcase
        end
        TRAP: state_d = TRAP;
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef PERF_CNT_EN
  // Free-running cycle and retired-instruction counters; cycle count freezes in TRAP
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt   <= 32'd0;
      instret_cnt <= 32'd0;
    end else begin
      if (state_q != TRAP)
        cycle_cnt <= cycle_cnt + 32'd1;
      if (retire)
        instret_cnt <= instret_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. Each cycle has a hand-written
// expected state and strobe set. Build with +define+PERF_CNT_EN to also check
// the performance counters.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] opcode = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       branch_taken = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_write, pc_src, ir_write, mem_req, mem_we, reg_write;
  logic [1:0] result_src, alu_op, trap_cause;
  logic       alu_src_a, alu_src_b, retire, trap;
  logic [2:0] state;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
    OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
    OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  // Strobe bundle bit positions
  localparam logic [13:0] PCW = 14'h2000, PCS = 14'h1000, IRW = 14'h0800, MREQ = 14'h0400,
    MWE = 14'h0200, RW = 14'h0100, RS_LD = 14'h0040, RS_PC = 14'h0080, RS_IMM = 14'h00C0,
    SA = 14'h0020, SB = 14'h0010, OPS = 14'h0004, OPF = 14'h0008, RET = 14'h0002,
    TRP = 14'h0001;

  logic [13:0] strobes;
  assign strobes = {pc_write, pc_src, ir_write, mem_req, mem_we, reg_write, result_src,
                    alu_src_a, alu_src_b, alu_op, retire, trap};

  multicycle_controller #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .mem_req(mem_req),
    .mem_we(mem_we), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .state(state),
    .retire(retire), .trap(trap), .trap_cause(trap_cause)
`ifdef PERF_CNT_EN
    , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after posedge, check, advance to next posedge+1
  task automatic cyc(input string tag, input logic mr, input logic bt,
                     input logic [2:0] es, input logic [13:0] ex);
    mem_ready    = mr;
    branch_taken = bt;
    #1;
    check_eq({tag, "_state"}, 32'(state), 32'(es));
    check_eq({tag, "_strb"}, 32'(strobes), 32'(ex));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst          = 1'b0;
    mem_ready    = 1'b0;
    branch_taken = 1'b0;
    @(negedge clk);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_strb", 32'(strobes), 32'd0);
    check_eq("rst_cause", 32'(trap_cause), 32'd0);
`ifdef PERF_CNT_EN
    check_eq("rst_cycle_cnt", cycle_cnt, 32'd0);
    check_eq("rst_instret_cnt", instret_cnt, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("rel_idle_strb", 32'(strobes), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    do_reset();

    // R-type, memory always ready
    opcode = OP_R;
    cyc("r_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("r_d", 1, 0, 3'd1, 14'h0);
    cyc("r_e", 1, 0, 3'd2, OPF);
    cyc("r_w", 1, 0, 3'd4, RW | RET);
`ifdef PERF_CNT_EN
    check_eq("r_instret_cnt", instret_cnt, 32'd1);
    check_eq("r_cycle_cnt", cycle_cnt, 32'd5);
`endif

    // I-type
    opcode = OP_I;
    cyc("i_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("i_d", 1, 0, 3'd1, 14'h0);
    cyc("i_e", 1, 0, 3'd2, OPF | SB);
    cyc("i_w", 1, 0, 3'd4, RW | RET);

    // LOAD: two wait cycles in FETCH, three in MEM
    opcode = OP_LOAD;
    for (int i = 0; i < 2; i++) cyc("ld_fw", 0, 0, 3'd0, MREQ);
    cyc("ld_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("ld_d", 1, 0, 3'd1, 14'h0);
    cyc("ld_e", 0, 0, 3'd2, SB);
    for (int i = 0; i < 3; i++) cyc("ld_mw", 0, 0, 3'd3, MREQ);
    cyc("ld_m", 1, 0, 3'd3, MREQ);
    cyc("ld_w", 1, 0, 3'd4, RW | RS_LD | RET);

    // STORE
    opcode = OP_STORE;
    cyc("st_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("st_d", 1, 0, 3'd1, 14'h0);
    cyc("st_e", 1, 0, 3'd2, SB);
    cyc("st_m", 1, 0, 3'd3, MREQ | MWE | RET);

    // BRANCH taken, then not taken
    opcode = OP_BRANCH;
    cyc("bt_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("bt_d", 1, 0, 3'd1, 14'h0);
    cyc("bt_e", 1, 1, 3'd2, PCW | PCS | OPS | RET);
    cyc("bn_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("bn_d", 1, 0, 3'd1, 14'h0);
    cyc("bn_e", 1, 0, 3'd2, PCS | OPS | RET);

    // JAL, JALR, LUI, AUIPC
    opcode = OP_JAL;
    cyc("jal_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("jal_d", 1, 0, 3'd1, 14'h0);
    cyc("jal_e", 1, 0, 3'd2, PCW | PCS | SA | SB);
    cyc("jal_w", 1, 0, 3'd4, RW | RS_PC | RET);
    opcode = OP_JALR;
    cyc("jalr_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("jalr_d", 1, 0, 3'd1, 14'h0);
    cyc("jalr_e", 1, 0, 3'd2, PCW | PCS | SB);
    cyc("jalr_w", 1, 0, 3'd4, RW | RS_PC | RET);
    opcode = OP_LUI;
    cyc("lui_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("lui_d", 1, 0, 3'd1, 14'h0);
    cyc("lui_e", 1, 0, 3'd2, 14'h0);
    cyc("lui_w", 1, 0, 3'd4, RW | RS_IMM | RET);
    opcode = OP_AUIPC;
    cyc("auipc_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("auipc_d", 1, 0, 3'd1, 14'h0);
    cyc("auipc_e", 1, 0, 3'd2, SA | SB);
    cyc("auipc_w", 1, 0, 3'd4, RW | RET);

    // Illegal opcode traps after DECODE and stays halted
    opcode = 7'b0000000;
    cyc("ill_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("ill_d", 1, 0, 3'd1, 14'h0);
    for (int i = 0; i < 3; i++) cyc("ill_trap", 1, 0, 3'd5, TRP);
    check_eq("ill_cause", 32'(trap_cause), 32'd1);
    do_reset();

    // mem_ready on the timeout cycle still wins
    opcode = OP_R;
    for (int i = 0; i < 15; i++) cyc("tw_w", 0, 0, 3'd0, MREQ);
    cyc("tw_rdy", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("tw_d", 1, 0, 3'd1, 14'h0);
    cyc("tw_e", 1, 0, 3'd2, OPF);
    cyc("tw_w4", 1, 0, 3'd4, RW | RET);

    // mem_ready never comes in FETCH: bus-timeout trap
    for (int i = 0; i < 16; i++) cyc("to_w", 0, 0, 3'd0, MREQ);
    cyc("to_trap", 0, 0, 3'd5, TRP);
    cyc("to_trap2", 1, 0, 3'd5, TRP);
    check_eq("to_cause", 32'(trap_cause), 32'd2);
    do_reset();

    // Reset during a MEM wait aborts the request immediately
    opcode = OP_LOAD;
    cyc("ab_f", 1, 0, 3'd0, MREQ | IRW | PCW);
    cyc("ab_d", 1, 0, 3'd1, 14'h0);
    cyc("ab_e", 0, 0, 3'd2, SB);
    cyc("ab_mw", 0, 0, 3'd3, MREQ);
    cyc("ab_mw2", 0, 0, 3'd3, MREQ);
    rst = 1'b0;
    #1;
    check_eq("ab_rst_state", 32'(state), 32'd0);
    check_eq("ab_rst_strb", 32'(strobes), 32'd0);
    do_reset();
    cyc("ab_refetch", 0, 0, 3'd0, MREQ);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
